uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
- Producer side of the instruction-memory interface: receives a program image over UART and writes 32-bit instruction words into instruction memory, which the fetch/decode path later consumes.
- Sits beside the instruction memory and is muxed in on the write port while `busy` is high; the CPU core is held off by the top level during loading.
- Frame format: header byte 0xA5, 16-bit word count N (little-endian), then 4*N data bytes. Each word is sent little-endian: byte0 is bits [7:0].

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. BIT_CYC = CLK_FREQ/BAUD, integer division (868 at defaults).
- ADDR_W, 14, word-address width of instruction memory. Maximum N is 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- rx  in  1  UART serial input; idle level is high; asynchronous to clk.
- start  in  1  one-cycle pulse that arms the loader; honoured only in IDLE, DONE or ERR.
- busy  out  1  high from the cycle after an accepted start until the loader enters DONE or ERR.
- done  out  1  level; high in DONE.
- err  out  1  level; high in ERR.
- we  out  1  one-cycle instruction-memory write strobe.
- waddr  out  ADDR_W  word address, valid when we=1.
- wdata  out  32  instruction word, valid when we=1.
- word_cnt  out  16  number of words written so far.

Behaviour:
- Reset: all outputs 0 and the FSM in IDLE. rx synchroniser flops reset to 1.
- Reset mid-load aborts the load immediately; memory words already written are left in place.
- RX path: 2-FF synchroniser on rx, then start-bit detection on a falling edge.
  - Wait BIT_CYC/2 cycles and recheck: if the line is high, treat it as a glitch and return to hunt.
  - Sample 8 data bits LSB-first, each BIT_CYC cycles apart, then the stop bit.
  - Stop bit = 0 is a framing error.
  - A good byte produces a one-cycle byte_vld pulse with the byte value.
- FSM states: IDLE -> HDR -> LEN0 -> LEN1 -> DATA -> (CSUM) -> DONE, with ERR reachable from HDR, LEN0, LEN1, DATA and CSUM.
  - IDLE/DONE/ERR + start: clear word_cnt, the byte index and done/err, then go to HDR.
  - HDR: byte 0xA5 -> LEN0; any other byte -> ERR.
  - LEN0: latch N[7:0]. LEN1: latch N[15:8].
  - After LEN1: N == 0 -> DONE; N > 2^ADDR_W -> ERR; otherwise -> DATA.
  - DATA: shift each byte into a 32-bit assembly register at position 8*idx. On the 4th byte, assert we for exactly one cycle with waddr = word_cnt[ADDR_W-1:0] and wdata = the assembled word, then increment word_cnt.
  - When word_cnt reaches N, go to DONE (or to CSUM if the optional feature is on).
- Any framing error while busy -> ERR.
- Bytes arriving in IDLE, DONE or ERR are received and discarded, with no state change.
- start while busy is ignored.
- Idle timeout: while busy, if no byte arrives for 16*10*BIT_CYC cycles -> ERR. The timeout counter restarts on every byte_vld.
- Latency: we asserts 1 cycle after the byte_vld of the 4th byte. DONE is entered in the same cycle as the last we.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Enabled: a CSUM state follows DATA and expects one byte equal to the XOR of all 4*N data bytes.
  - Match -> DONE; mismatch -> ERR.
  - For N == 0 the expected checksum is 0x00.
- Disabled: no CSUM state and no XOR register; DATA -> DONE directly.

Decomposition:
- Shared package:
  - state encoding typedef (IDLE, HDR, LEN0, LEN1, DATA, CSUM, DONE, ERR);
  - header constant 0xA5;
  - timeout multiplier constant 16.
- Sub-module uart_rx_byte (synchroniser, bit timer, shift register, byte_vld/frame_err outputs), parameterised by BIT_CYC.

Test Plan:
1. start, then A5 02 00 13 00 00 00 93 00 10 00:
   - we at waddr 0, wdata 0x00000013; we at waddr 1, wdata 0x00100093;
   - word_cnt = 2, done = 1, busy = 0.
2. start, then byte 0x5A: err = 1, no we. A following start plus a valid 1-word frame gives done = 1 and err = 0.
3. start, A5 00 00: done = 1 with zero writes. With PROG_LOADER_CHECKSUM_EN, checksum byte 00 is required first.
4. Framing error: stop bit driven 0 on the third data byte -> err = 1 and word_cnt unchanged at 0.
5. Reset asserted mid-word (after 2 of 4 bytes): all outputs 0 immediately. After release, a new start plus a full frame loads correctly from waddr 0.
6. PROG_LOADER_CHECKSUM_EN with words 0x00000013 and 0x00100093: checksum 0x90 -> done = 1; checksum 0x91 -> err = 1, with both we pulses still observed.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the UART program loader.
// Contents: the loader FSM state encoding, the frame header byte and the
// idle-timeout multiplier, which counts 10-bit byte times.
package uart_prog_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_HDR  = 3'd1;
  localparam state_t ST_LEN0 = 3'd2;
  localparam state_t ST_LEN1 = 3'd3;
  localparam state_t ST_DATA = 3'd4;
  localparam state_t ST_CSUM = 3'd5;
  localparam state_t ST_DONE = 3'd6;
  localparam state_t ST_ERR  = 3'd7;

  localparam logic [7:0] HDR_BYTE     = 8'hA5;
  localparam int         TIMEOUT_MULT = 16;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Instruction-memory write port driven by the program loader.
//   we    : one-cycle write strobe
//   waddr : word address, valid with we
//   wdata : 32-bit instruction word, valid with we
// The master modport is the loader. The slave modport is the memory-side mux.
interface uart_prog_loader_if #(parameter int ADDR_W = 14);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  modport master (output we, waddr, wdata);
  modport slave  (input  we, waddr, wdata);
endinterface

// File: rtl/uart_prog_loader_rx.sv
// UART byte receiver, 8N1, LSB first.
//   clk, rstn : system clock and asynchronous active-low reset
//   rx        : serial input, idle high, asynchronous to clk
//   byte_vld  : one-cycle pulse when a byte is received with a good stop bit
//   byte_data : received byte, valid with byte_vld
//   frame_err : one-cycle pulse when the stop bit is sampled low
module uart_rx_byte
  import uart_prog_loader_pkg::*;
#(
  parameter int BIT_CYC = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic       byte_vld,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int               TMR_W    = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
  localparam logic [TMR_W-1:0] HALF_CYC = TMR_W'(BIT_CYC / 2 - 1);
  localparam logic [TMR_W-1:0] FULL_CYC = TMR_W'(BIT_CYC - 1);

  localparam logic [1:0] RX_HUNT  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic             rx_meta, rx_sync, rx_prev;
  logic [1:0]       rx_state;
  logic [TMR_W-1:0] tmr;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  // Synchroniser and the edge-detect flop reset to the idle (high) level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Once a start bit is confirmed at mid-bit, each later sample is taken
  // a full bit time after the previous one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state  <= RX_HUNT;
      tmr       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_HUNT: begin
          if (rx_prev && !rx_sync) begin
            tmr      <= HALF_CYC;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else if (rx_sync) begin
            rx_state <= RX_HUNT;
          end else begin
            tmr      <= FULL_CYC;
            bit_idx  <= '0;
            rx_state <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            shreg   <= {rx_sync, shreg[7:1]};
            tmr     <= FULL_CYC;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end
        end
        default: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else begin
            byte_vld  <= rx_sync;
            frame_err <= !rx_sync;
            rx_state  <= RX_HUNT;
          end
        end
      endcase
    end
  end

  assign byte_data = shreg;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: receives "A5, N (16-bit LE), 4*N bytes" and writes
// N little-endian 32-bit words to instruction memory from address 0.
//   clk, rstn : system clock and asynchronous active-low reset
//   rx        : UART serial input
//   start     : arming pulse; accepted only in IDLE, DONE or ERR
//   busy      : loader active (HDR..CSUM)
//   done, err : terminal status levels
//   word_cnt  : words written so far
//   imem      : instruction-memory write port (we/waddr/wdata)
// Optional build macro PROG_LOADER_CHECKSUM_EN appends a checksum byte to the
// frame. That byte must equal the XOR of all data bytes.
//
// state | meaning
// IDLE  | after reset, waiting for start
// HDR   | expecting header byte 0xA5
// LEN0  | word count low byte
// LEN1  | word count high byte, then range check
// DATA  | assembling and writing words
// CSUM  | expecting XOR checksum byte (checksum build only)
// DONE  | image loaded
// ERR   | bad header, oversize count, framing error, timeout or bad checksum
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200,
  parameter int ADDR_W   = 14
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               rx,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [15:0]        word_cnt,
  uart_prog_loader_if.master imem
);

  localparam int            BIT_CYC = CLK_FREQ / BAUD;
  localparam int            TO_CYC  = TIMEOUT_MULT * 10 * BIT_CYC;
  localparam int            TO_W    = $clog2(TO_CYC);
  localparam logic [TO_W-1:0] TO_INIT = TO_W'(TO_CYC - 1);
  localparam logic [16:0]   N_MAX   = 17'(2 ** ADDR_W);
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t ST_TAIL = ST_CSUM;
`else
  localparam state_t ST_TAIL = ST_DONE;
`endif

  logic              byte_vld, frame_err;
  logic [7:0]        byte_data;
  state_t            state;
  logic [15:0]       n_words;
  logic [1:0]        idx;
  logic [23:0]       asm_q;
  logic [TO_W-1:0]   to_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic [16:0]       n_full;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  uart_rx_byte #(.BIT_CYC(BIT_CYC)) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .byte_vld  (byte_vld),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  assign n_full = {1'b0, byte_data, n_words[7:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      n_words  <= '0;
      idx      <= '0;
      asm_q    <= '0;
      to_cnt   <= '0;
      word_cnt <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state    <= ST_HDR;
            word_cnt <= '0;
            idx      <= '0;
            to_cnt   <= TO_INIT;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        default: begin
          if (frame_err || to_cnt == '0) begin
            state <= ST_ERR;
          end else if (byte_vld) begin
            to_cnt <= TO_INIT;
            case (state)
              ST_HDR:  state <= (byte_data == HDR_BYTE) ? ST_LEN0 : ST_ERR;
              ST_LEN0: begin
                n_words[7:0] <= byte_data;
                state        <= ST_LEN1;
              end
              ST_LEN1: begin
                n_words[15:8] <= byte_data;
                if (n_full == '0)        state <= ST_TAIL;
                else if (n_full > N_MAX) state <= ST_ERR;
                else                     state <= ST_DATA;
              end
              ST_DATA: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                csum <= csum ^ byte_data;
`endif
                idx <= idx + 2'd1;
                // Bytes arrive low first, so shifting down leaves byte k at bits 8k.
                if (idx == 2'd3) begin
                  we_q     <= 1'b1;
                  waddr_q  <= word_cnt[ADDR_W-1:0];
                  wdata_q  <= {byte_data, asm_q};
                  word_cnt <= word_cnt + 16'd1;
                  if (word_cnt + 16'd1 == n_words) state <= ST_TAIL;
                end else begin
                  asm_q <= {byte_data, asm_q[23:8]};
                end
              end
`ifdef PROG_LOADER_CHECKSUM_EN
              ST_CSUM: state <= (byte_data == csum) ? ST_DONE : ST_ERR;
`endif
              default: ;
            endcase
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign busy       = !(state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign done       = (state == ST_DONE);
  assign err        = (state == ST_ERR);
  assign imem.we    = we_q;
  assign imem.waddr = waddr_q;
  assign imem.wdata = wdata_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: frames go in over a bit-banged UART line.
// Each write the frame should cause is queued when the frame is issued.
// A negedge monitor pops and compares each memory write.
module tb_uart_prog_loader;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int ADDR_W   = 3;
  localparam int MAXN     = 1 << ADDR_W;
  localparam int TO_CYC   = 16 * 10 * BIT_CYC;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [15:0] word_cnt;

  uart_prog_loader_if #(.ADDR_W(ADDR_W)) imem ();

  uart_prog_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx       (rx),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .word_cnt (word_cnt),
    .imem     (imem)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              last;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (imem.we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", imem.waddr, imem.wdata);
      end else begin
        e = exp_q.pop_front();
        check("waddr", 32'(imem.waddr), 32'(e.addr));
        check("wdata", imem.wdata, e.data);
        if (e.last) check("done_with_last_we", 32'(done), 32'd1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0;
    repeat (BIT_CYC) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CYC) @(posedge clk);
    end
    rx = stop_bit;
    repeat (BIT_CYC) @(posedge clk);
    rx = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("busy_end", 32'(busy), 32'd0);
  endtask

  // Reference: a frame either loads all N words (done) or fails at the count
  // check or, with the checksum build, at a corrupted checksum byte.
  task automatic run_frame(input int n, input logic [31:0] words[$], input bit bad_csum, input bit mid_start);
    logic [15:0] nn;
    logic [7:0]  cs;
    logic [31:0] wd;
    bit          exp_err;
    int          exp_wc;
    wr_t         e;
    nn      = 16'(n);
    cs      = 8'h00;
    exp_err = 1'b0;
    exp_wc  = n;
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    send_byte(8'hA5);
    if (mid_start) pulse_start();
    send_byte(nn[7:0]);
    send_byte(nn[15:8]);
    if (n > MAXN) begin
      exp_err = 1'b1;
      exp_wc  = 0;
    end else begin
      for (int w = 0; w < n; w++) begin
        wd     = words[w];
        e.addr = ADDR_W'(w);
        e.data = wd;
`ifdef PROG_LOADER_CHECKSUM_EN
        e.last = 1'b0;
`else
        e.last = (w == n - 1);
`endif
        exp_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
          cs = cs ^ wd[8*k +: 8];
          send_byte(wd[8*k +: 8]);
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      send_byte(bad_csum ? (cs ^ 8'h01) : cs);
      exp_err = bad_csum;
`endif
    end
    wait_idle(4 * BIT_CYC);
    check("err", 32'(err), 32'(exp_err));
    check("done", 32'(done), 32'(!exp_err));
    check("word_cnt", 32'(word_cnt), 32'(exp_wc));
    check("pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] q_prog[$];
    logic [31:0] q_one[$];
    logic [31:0] q_none[$];
    logic [31:0] q_rnd[$];
    int          n;
    int          k;
    bit          bc;

    q_prog = '{32'h0000_0013, 32'h0010_0093};
    q_one  = '{32'hDEAD_BEEF};

    repeat (5) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    check("rst_we", 32'(imem.we), 32'd0);
    rstn = 1'b1;
    repeat (3) @(posedge clk);

    // bytes in IDLE are ignored
    send_byte(8'hA5);
    #1;
    check("idle_byte_busy", 32'(busy), 32'd0);
    check("idle_byte_done", 32'(done), 32'd0);

    // test 1 (with a start pulse while busy that must be ignored)
    run_frame(2, q_prog, 1'b0, 1'b1);
    send_byte(8'h13);
    #1;
    check("done_byte_done", 32'(done), 32'd1);
    check("done_byte_word_cnt", 32'(word_cnt), 32'd2);

    // test 2: bad header, then recovery
    pulse_start();
    send_byte(8'h5A);
    #1;
    check("hdr_err", 32'(err), 32'd1);
    check("hdr_word_cnt", 32'(word_cnt), 32'd0);
    run_frame(1, q_one, 1'b0, 1'b0);

    // test 3: empty image
    run_frame(0, q_none, 1'b0, 1'b0);

    // oversize count and full-size image
    run_frame(MAXN + 1, q_none, 1'b0, 1'b0);
    q_rnd = {};
    for (int i = 0; i < MAXN; i++) q_rnd.push_back($urandom);
    run_frame(MAXN, q_rnd, 1'b0, 1'b0);

    // test 4: framing error on third data byte
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33, 1'b0);
    #1;
    check("frame_err", 32'(err), 32'd1);
    check("frame_word_cnt", 32'(word_cnt), 32'd0);

    // test 5: reset mid-word
    pulse_start();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h44);
    send_byte(8'h55);
    rstn = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_word_cnt", 32'(word_cnt), 32'd0);
    check("midrst_waddr", 32'(imem.waddr), 32'd0);
    check("midrst_wdata", imem.wdata, 32'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    run_frame(2, q_prog, 1'b0, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    // test 6: bad checksum 0x91
    run_frame(2, q_prog, 1'b1, 1'b0);
`endif

    // idle timeout
    pulse_start();
    send_byte(8'hA5);
    repeat (TO_CYC / 2) @(posedge clk);
    #1;
    check("no_early_timeout", 32'(busy), 32'd1);
    k = 0;
    while (!err && k < TO_CYC) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("timeout_err", 32'(err), 32'd1);

    // randomized frames
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(0, MAXN + 1);
      q_rnd = {};
      if (n <= MAXN) for (int i = 0; i < n; i++) q_rnd.push_back($urandom);
`ifdef PROG_LOADER_CHECKSUM_EN
      bc = ($urandom_range(0, 1) == 1);
`else
      bc = 1'b0;
`endif
      run_frame(n, q_rnd, bc, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
